// File: rtl/rd_addr_phase_if.sv
// Bundle of the AR channel and the downstream command port of the read-address front end.
// The slave modport is the front end's view; master is the driving environment.
interface rd_addr_phase_if #(
    parameter int AXI_AW = 32,
    parameter int AXI_IW = 4,
    parameter int DEPTH  = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AXI_IW-1:0] axi_arid_i;
    logic [AXI_AW-1:0] axi_araddr_i;
    logic [7:0]        axi_arlen_i;
    logic [2:0]        axi_arsize_i;
    logic [1:0]        axi_arburst_i;
    logic              axi_arvalid_i;
    logic              axi_arready_o;

    logic              req_valid_o;
    logic              req_ready_i;
    logic [AXI_IW-1:0] req_id_o;
    logic [AXI_AW-1:0] req_addr_o;
    logic [7:0]        req_len_o;
    logic [2:0]        req_size_o;
    logic [1:0]        req_burst_o;
    logic [AXI_AW-1:0] req_wrap_lo_o;
    logic [AXI_AW-1:0] req_wrap_hi_o;
    logic              req_err_o;
    logic [CW-1:0]     req_count_o;

    modport slave (
        input  axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i,
        input  axi_arvalid_i, req_ready_i,
        output axi_arready_o, req_valid_o, req_id_o, req_addr_o, req_len_o,
        output req_size_o, req_burst_o, req_wrap_lo_o, req_wrap_hi_o, req_err_o,
        output req_count_o
    );

    modport master (
        output axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i,
        output axi_arvalid_i, req_ready_i,
        input  axi_arready_o, req_valid_o, req_id_o, req_addr_o, req_len_o,
        input  req_size_o, req_burst_o, req_wrap_lo_o, req_wrap_hi_o, req_err_o,
        input  req_count_o
    );
endinterface

// File: rtl/rd_addr_phase.sv
// AXI4 read-address front end: legality check, wrap-boundary precompute and an in-order
// request FIFO whose head is held in a registered output stage for the read-data stage.
module rd_addr_phase #(
    parameter int AXI_DW = 256,
    parameter int AXI_AW = 32,
    parameter int AXI_IW = 4,
    parameter int DEPTH  = 8,
    parameter int AXI_SW = AXI_DW >> 3
) (
    input  logic               axi_clk_i,
    input  logic               axi_rstn_i,
    rd_addr_phase_if.slave     bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW_LOG = $clog2(AXI_SW);

    localparam logic [AXI_AW-1:0] ONE_AW   = {{(AXI_AW-1){1'b0}}, 1'b1};
    localparam logic [AXI_AW-1:0] ZERO_AW  = {AXI_AW{1'b0}};
    localparam logic [CW-1:0]     ZERO_CW  = {CW{1'b0}};
    localparam logic [CW-1:0]     DEPTH_CW = CW'(DEPTH);
    localparam logic [2:0]        SW_LOG3  = 3'(SW_LOG);

    typedef struct packed {
        logic [AXI_IW-1:0] id;
        logic [AXI_AW-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [AXI_AW-1:0] lo;
        logic [AXI_AW-1:0] hi;
        logic              err;
    } entry_t;

    localparam entry_t ENTRY_ZERO = {$bits(entry_t){1'b0}};

    // Full queue entry for one AR beat: boundaries and the legality verdict.
    function automatic entry_t build_entry(
        input logic [AXI_IW-1:0] id,
        input logic [AXI_AW-1:0] addr,
        input logic [7:0]        len,
        input logic [2:0]        size,
        input logic [1:0]        burst
    );
        entry_t            e;
        logic [AXI_AW-1:0] beat_bytes;
        logic [AXI_AW-1:0] total_bytes;
        logic [AXI_AW-1:0] beat_mask;
        logic [AXI_AW-1:0] hi_m1;
        beat_bytes  = ONE_AW << size;
        total_bytes = ({{(AXI_AW-8){1'b0}}, len} + ONE_AW) << size;
        beat_mask   = beat_bytes - ONE_AW;
        e.id    = id;
        e.addr  = addr;
        e.len   = len;
        e.size  = size;
        e.burst = burst;
        e.lo    = addr;
        e.hi    = addr + total_bytes;
        e.err   = 1'b0;
        hi_m1   = ZERO_AW;
        case (burst)
            2'b00: begin
                e.hi  = addr + beat_bytes;
                e.err = (len > 8'd15);
            end
            2'b01: begin
                // INCR upper bound starts from the size-aligned address; the last byte
                // must share the 4 KB page of the start address.
                e.hi  = (addr & ~beat_mask) + total_bytes;
                hi_m1 = e.hi - ONE_AW;
                e.err = (hi_m1[AXI_AW-1:12] != addr[AXI_AW-1:12]);
            end
            2'b10: begin
                e.lo  = addr & ~(total_bytes - ONE_AW);
                e.hi  = e.lo + total_bytes;
                e.err = !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15))
                        || ((addr & beat_mask) != ZERO_AW);
            end
            default: begin
                e.err = 1'b1;
            end
        endcase
        e.err = e.err | (size > SW_LOG3);
        return e;
    endfunction

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    entry_t          head_q, head_d;
    entry_t          new_entry_s;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            valid_q, valid_d;
    logic            arready_q, arready_d;
    logic            push_s, pop_s;

    // Handshakes and the entry that would be captured on this edge.
    always_comb begin
        push_s      = bus.axi_arvalid_i & arready_q;
        pop_s       = valid_q & bus.req_ready_i;
        new_entry_s = build_entry(bus.axi_arid_i, bus.axi_araddr_i, bus.axi_arlen_i,
                                  bus.axi_arsize_i, bus.axi_arburst_i);
    end

    // Pointer, occupancy and storage updates.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push_s) begin
            wr_ptr_d        = wr_ptr_q + 1'b1;
            mem_d[wr_ptr_q] = new_entry_s;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Next head register and AR-ready; a push into an otherwise empty queue is
    // forwarded straight into the head since its slot is not yet written.
    always_comb begin
        valid_d   = (count_d != ZERO_CW);
        arready_d = (count_d < DEPTH_CW);
        head_d    = ENTRY_ZERO;
        if (!valid_d) begin
            head_d = ENTRY_ZERO;
        end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            head_d = new_entry_s;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // State registers; reset discards every buffered request at once.
    always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
        if (!axi_rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= ENTRY_ZERO;
            end
            head_q    <= ENTRY_ZERO;
            wr_ptr_q  <= {PW{1'b0}};
            rd_ptr_q  <= {PW{1'b0}};
            count_q   <= ZERO_CW;
            valid_q   <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            head_q    <= head_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            arready_q <= arready_d;
        end
    end

    assign bus.axi_arready_o = arready_q;
    assign bus.req_valid_o   = valid_q;
    assign bus.req_id_o      = head_q.id;
    assign bus.req_addr_o    = head_q.addr;
    assign bus.req_len_o     = head_q.len;
    assign bus.req_size_o    = head_q.size;
    assign bus.req_burst_o   = head_q.burst;
    assign bus.req_wrap_lo_o = head_q.lo;
    assign bus.req_wrap_hi_o = head_q.hi;
    assign bus.req_err_o     = head_q.err;
    assign bus.req_count_o   = count_q;

endmodule
